// File: rtl/mod_cnt_arbiter.sv
// Round-robin arbiter for one shared modulo counter; the winner owns it for M cycles.
// Optional macro CNT_PAUSE_EN adds a pause input that freezes a run in progress.
module mod_cnt_arbiter #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
`ifdef CNT_PAUSE_EN
  input  logic          pause,
`endif
  input  logic [2:0]    req,
  input  logic [CW-1:0] mod0,
  input  logic [CW-1:0] mod1,
  input  logic [CW-1:0] mod2,
  output logic [2:0]    grant,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          tc,
  output logic [2:0]    done
);

  localparam int unsigned NREQ = 3;
  localparam int unsigned IW   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    grant_q, grant_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] count_q, count_d;
  logic          tc_q, tc_d;
  logic [2:0]    done_q, done_d;
  logic [CW-1:0] m_q, m_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;

  logic          found_c;
  logic [IW-1:0] win_c;
  logic [CW-1:0] mod_sel_c;
  logic [CW-1:0] m_last_c;
  logic [CW-1:0] inc_c;
  logic          pause_c;

`ifdef CNT_PAUSE_EN
  assign pause_c = pause;
`else
  assign pause_c = 1'b0;
`endif

  // Round-robin search starting at the index after the last grant.
  always_comb begin
    logic [IW-1:0] cand;
    found_c = 1'b0;
    win_c   = '0;
    cand    = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IW'((32'(ptr_q) + i) % NREQ);
      if (!found_c && req[cand]) begin
        found_c = 1'b1;
        win_c   = cand;
      end
    end
  end

  always_comb begin
    case (win_c)
      2'd0:    mod_sel_c = mod0;
      2'd1:    mod_sel_c = mod1;
      default: mod_sel_c = mod2;
    endcase
  end

  assign m_last_c = CW'(m_q - CW'(1));
  assign inc_c    = CW'(count_q + CW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= '0;
      m_q     <= CW'(2);
      owner_q <= '0;
      ptr_q   <= IW'(2);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      m_q     <= m_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = '0;
    m_d     = m_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
        if (found_c) begin
          state_d = RUN;
          grant_d = 3'b001 << win_c;
          busy_d  = 1'b1;
          owner_d = win_c;
          ptr_d   = win_c;
          m_d     = (mod_sel_c < CW'(2)) ? CW'(2) : mod_sel_c;
        end
      end
      RUN: begin
        // Owner withdrawal wins over pause and terminal count.
        if (!req[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          count_d = '0;
        end else if (pause_c) begin
          count_d = count_q;
        end else if (count_q == m_last_c) begin
          state_d = DONE;
          count_d = '0;
          done_d  = grant_q;
        end else begin
          count_d = inc_c;
          tc_d    = (inc_c == m_last_c);
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign count = count_q;
  assign tc    = tc_q;
  assign done  = done_q;

endmodule

// File: tb/tb_mod_cnt_arbiter.sv
// Bench for mod_cnt_arbiter: per-cycle expected output snapshots are queued, then
// popped and compared at each falling edge.
module tb_mod_cnt_arbiter;

  localparam int unsigned CW = 4;

  typedef struct packed {
    logic [2:0]    grant;
    logic          busy;
    logic [CW-1:0] count;
    logic          tc;
    logic [2:0]    done;
  } snap_t;

  logic          clk;
  logic          rst;
  logic          pause;
  logic [2:0]    req;
  logic [CW-1:0] mod0, mod1, mod2;
  logic [2:0]    grant;
  logic          busy;
  logic [CW-1:0] count;
  logic          tc;
  logic [2:0]    done;

  int total;
  int bad;
  snap_t sb_q[$];

  mod_cnt_arbiter #(.CW(CW)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef CNT_PAUSE_EN
    .pause(pause),
`endif
    .req  (req),
    .mod0 (mod0),
    .mod1 (mod1),
    .mod2 (mod2),
    .grant(grant),
    .busy (busy),
    .count(count),
    .tc   (tc),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic snap_t mk(logic [2:0] g, logic b, int c, logic t, logic [2:0] d);
    snap_t s;
    s.grant = g;
    s.busy  = b;
    s.count = CW'(c);
    s.tc    = t;
    s.done  = d;
    return s;
  endfunction

  function automatic snap_t observe();
    return {grant, busy, count, tc, done};
  endfunction

  // Expected trace of one complete run of length m for one-hot owner g.
  function automatic void push_run(logic [2:0] g, int m);
    for (int c = 0; c < m; c++) sb_q.push_back(mk(g, 1'b1, c, (c == m - 1), 3'b000));
    sb_q.push_back(mk(g, 1'b1, 0, 1'b0, g));
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    req = 3'b000;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    snap_t o;
    @(negedge clk);
    o = observe();
    total++;
    if (o !== mk(3'b000, 1'b0, 0, 1'b0, 3'b000)) begin
      bad++;
      $display("FAIL reset got=%b exp=%b", o, mk(3'b000, 1'b0, 0, 1'b0, 3'b000));
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    snap_t e, o;
    int n;
    req  = 3'b001;
    mod0 = CW'(7);
    push_run(3'b001, 7);
    sb_q.push_back(mk(3'b000, 1'b0, 0, 1'b0, 3'b000));
    n = sb_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL single[%0d] got=%b exp=%b", i, o, e);
      end
      if (i == 7) req = 3'b000;
    end
  endtask

  task automatic test_round_robin();
    snap_t e, o;
    int n;
    logic [2:0] order [4];
    order[0] = 3'b001; order[1] = 3'b010; order[2] = 3'b100; order[3] = 3'b001;
    pulse_reset();
    mod0 = CW'(3); mod1 = CW'(3); mod2 = CW'(3);
    req  = 3'b111;
    for (int g = 0; g < 4; g++) begin
      push_run(order[g], 3);
      sb_q.push_back(mk(3'b000, 1'b0, 0, 1'b0, 3'b000));
    end
    n = sb_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL round_robin[%0d] got=%b exp=%b", i, o, e);
      end
      if (i == n - 2) req = 3'b000;
    end
  endtask

  task automatic test_min_mod();
    snap_t e, o;
    int n;
    req  = 3'b010;
    mod1 = CW'(0);
    push_run(3'b010, 2);
    sb_q.push_back(mk(3'b000, 1'b0, 0, 1'b0, 3'b000));
    n = sb_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL min_mod[%0d] got=%b exp=%b", i, o, e);
      end
      if (i == 2) req = 3'b000;
    end
  endtask

  task automatic test_abort();
    snap_t e, o;
    int n;
    req  = 3'b001;
    mod0 = CW'(9);
    for (int c = 0; c <= 4; c++) sb_q.push_back(mk(3'b001, 1'b1, c, 1'b0, 3'b000));
    sb_q.push_back(mk(3'b000, 1'b0, 0, 1'b0, 3'b000));
    sb_q.push_back(mk(3'b000, 1'b0, 0, 1'b0, 3'b000));
    n = sb_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL abort[%0d] got=%b exp=%b", i, o, e);
      end
      if (i == 4) begin
        req  = 3'b000;
        mod0 = CW'(2);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    snap_t e, o;
    int n;
    req  = 3'b001;
    mod0 = CW'(9);
    mod1 = CW'(4);
    for (int c = 0; c <= 3; c++) sb_q.push_back(mk(3'b001, 1'b1, c, 1'b0, 3'b000));
    sb_q.push_back(mk(3'b000, 1'b0, 0, 1'b0, 3'b000));
    sb_q.push_back(mk(3'b010, 1'b1, 0, 1'b0, 3'b000));
    sb_q.push_back(mk(3'b010, 1'b1, 1, 1'b0, 3'b000));
    sb_q.push_back(mk(3'b000, 1'b0, 0, 1'b0, 3'b000));
    n = sb_q.size();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL rst_run[%0d] got=%b exp=%b", i, o, e);
      end
    end
    rst = 1'b1;
    req = 3'b110;
    #1;
    e = sb_q.pop_front();
    o = observe();
    total++;
    if (o !== e) begin
      bad++;
      $display("FAIL rst_async got=%b exp=%b", o, e);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 5; i < n; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL rst_regrant[%0d] got=%b exp=%b", i, o, e);
      end
      if (i == 6) req = 3'b000;
    end
  endtask

`ifdef CNT_PAUSE_EN
  task automatic test_pause();
    snap_t e, o;
    int n;
    int cnt_seq [8];
    cnt_seq[0] = 0; cnt_seq[1] = 1; cnt_seq[2] = 2; cnt_seq[3] = 2;
    cnt_seq[4] = 2; cnt_seq[5] = 2; cnt_seq[6] = 3; cnt_seq[7] = 4;
    req  = 3'b001;
    mod0 = CW'(5);
    for (int i = 0; i < 8; i++) sb_q.push_back(mk(3'b001, 1'b1, cnt_seq[i], (i == 7), 3'b000));
    sb_q.push_back(mk(3'b001, 1'b1, 0, 1'b0, 3'b001));
    sb_q.push_back(mk(3'b000, 1'b0, 0, 1'b0, 3'b000));
    n = sb_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = sb_q.pop_front();
      o = observe();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL pause[%0d] got=%b exp=%b", i, o, e);
      end
      if (i == 2) pause = 1'b1;
      if (i == 5) pause = 1'b0;
      if (i == 8) req = 3'b000;
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    pause = 1'b0;
    req   = 3'b000;
    mod0  = '0;
    mod1  = '0;
    mod2  = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_min_mod();
    test_abort();
    test_reset_mid_run();
`ifdef CNT_PAUSE_EN
    test_pause();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_cnt_arbiter.md
MOD_CNT_ARBITER -- requirements
Module: mod_cnt_arbiter

Interface
REQ-001 The block SHALL have parameter CW, default 4, setting the width of the counter and each modulus.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port req, input, 3 bits: level request per requester, held until done or withdrawn.
REQ-005 The block SHALL have ports mod0, mod1 and mod2, input, CW bits each: requested modulus per requester.
REQ-006 The block SHALL have port grant, output, 3 bits: one-hot owner of the shared counter, all zero when there is no owner.
REQ-007 The block SHALL have port busy, output, 1 bit: high in states RUN and DONE.
REQ-008 The block SHALL have port count, output, CW bits: shared modulo counter value.
REQ-009 The block SHALL have port tc, output, 1 bit: terminal-count strobe.
REQ-010 The block SHALL have port done, output, 3 bits: one-cycle completion pulse per requester.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, RUN and DONE, with all outputs registered.
REQ-012 In IDLE, if any req bit is high, the block SHALL select a requester round-robin, starting from the index after the last granted one (initial pointer 2, so index 0 is checked first), and enter RUN on the next edge.
REQ-013 On entering RUN, the block SHALL set grant one-hot to the winner, set count to 0, and latch the winner's modulus M, with M below 2 replaced by 2.
REQ-014 In RUN, count SHALL increment by 1 each cycle.
REQ-015 tc SHALL be high exactly during the cycle in which count equals M-1.
REQ-016 On the edge after count equals M-1, the block SHALL set count to 0 and enter DONE, so RUN lasts exactly M cycles.
REQ-017 In DONE, done[winner] SHALL be high for one cycle with grant held; the next edge SHALL clear grant and return to IDLE.
REQ-018 The earliest regrant SHALL be one cycle after DONE, so there are M+2 cycles between consecutive grants with one IDLE gap cycle.
REQ-019 If the owner's req falls during RUN, the block SHALL abort on the next edge: IDLE, grant 0, count 0, no done and no tc pulse after the abort.
REQ-020 mod inputs SHALL be ignored after latching; changes during RUN have no effect.
REQ-021 Requests arriving while busy SHALL wait, and none SHALL be dropped.
REQ-022 The round-robin pointer SHALL update only when a grant is issued, not when a run is aborted.
REQ-023 Counter arithmetic SHALL be CW bits wide and never exceed M-1; with M equal to 2^CW-1 the maximum count is 2^CW-2.

Reset
REQ-024 While rst is high, the block SHALL force state IDLE, grant 0, busy 0, count 0, tc 0, done 0 and round-robin pointer 2, asynchronously.
REQ-025 Reset asserted mid-RUN SHALL discard the run without a done pulse, and the first arbitration after release SHALL favour requester 0.

Configuration
REQ-026 With macro CNT_PAUSE_EN defined, the block SHALL add a 1-bit input pause; while pause is high in RUN, count and state SHALL hold and tc SHALL be 0.
REQ-027 With CNT_PAUSE_EN defined, pause SHALL have no effect in IDLE or DONE, and an owner's req falling while paused SHALL still abort.
REQ-028 Without CNT_PAUSE_EN, the pause port SHALL be absent and count SHALL advance every RUN cycle.

Verification
REQ-029 The bench SHALL drive req=001, mod0=7 and check: grant=001 one cycle later, count 0..6, tc high at count 6, done=001 one cycle after that, then grant=000.
REQ-030 The bench SHALL hold req=111 continuously with all mods=3 and check the grant order 001, 010, 100, 001 with 5 cycles between grants.
REQ-031 The bench SHALL drive req=010, mod1=0 and check that it runs as M=2: count 0,1, tc at count 1, then done=010.
REQ-032 The bench SHALL drive req=001, mod0=9, drop req at count 4, and check: next cycle grant=000, count=0, done=000, no tc.
REQ-033 The bench SHALL assert rst mid-RUN at count 3 and check all outputs are 0 immediately; after release with req=110, grant=010 first.
REQ-034 With CNT_PAUSE_EN defined, the bench SHALL drive mod0=5 and pause high for 3 cycles at count 2, and check count holds at 2 for 3 cycles and total RUN length is 8 cycles.
